sfr_write_sched: RTL and testbench

Write-port scheduler for the special function register file in the memory stage. Up to five pipeline sources can request an SFR write in the same cycle: EX/MEM bottom, MEM/WB top and bottom, and MEM/WB t-1 top and bottom. The SFR file has one write port. This block grants one source per cycle in program order. It drives the one-hot select of the SFR input multiplexer, plus the write enable and address. While any requests remain unserved it holds the pipeline through `stall`.

---
 rtl/sfr_write_sched_pkg.sv | 27 ++
 rtl/sfr_prio_pick.sv | 26 ++
 rtl/sfr_write_sched.sv | 99 +++++++++
 tb/tb_sfr_write_sched.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sfr_write_sched_pkg.sv
// Shared definitions for the SFR write-port scheduler: source indices,
// grant priority order and scheduler state encoding.
package sfr_write_sched_pkg;

    localparam int N_SRC = 5;

    localparam int SRC_EXMEM_BOT = 0;
    localparam int SRC_MEMWB_TOP = 1;
    localparam int SRC_MEMWB_BOT = 2;
    localparam int SRC_TM1_TOP   = 3;
    localparam int SRC_TM1_BOT   = 4;

    // Oldest instruction first, top before bot within an instruction.
    localparam int PRIO_ORDER [N_SRC] = '{
        SRC_TM1_TOP,
        SRC_TM1_BOT,
        SRC_MEMWB_TOP,
        SRC_MEMWB_BOT,
        SRC_EXMEM_BOT
    };

    typedef enum logic {
        SCHED_IDLE  = 1'b0,
        SCHED_DRAIN = 1'b1
    } sched_state_t;

endpackage

// File: rtl/sfr_prio_pick.sv
// Combinational fixed-priority picker: one-hot grant of the oldest pending
// source, plus a flag saying more than one source is pending.
module sfr_prio_pick
    import sfr_write_sched_pkg::*;
(
    input  logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] grant,
    output logic             multi
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && pending[PRIO_ORDER[i]]) begin
                grant[PRIO_ORDER[i]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

    assign multi = (pending & (pending - 1'b1)) != '0;

endmodule

// File: rtl/sfr_write_sched.sv
// SFR write-port scheduler: serialises up to five same-cycle SFR write
// requests onto the single write port, stalling the pipeline meanwhile.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   SCHED_IDLE  | no source of the current group written yet (served==0)
//   SCHED_DRAIN | some sources written, others still pending; stall high
module sfr_write_sched
    import sfr_write_sched_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [N_SRC-1:0]  req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [ADDR_W-1:0] addr4,
    output logic [N_SRC-1:0]  sel_signals,
    output logic              sfr_wr_en,
    output logic [ADDR_W-1:0] sfr_wr_addr,
    output logic              stall
);

    sched_state_t      state_q, state_d;
    logic [N_SRC-1:0]  served_q, served_d;
    logic [N_SRC-1:0]  served_eff;
    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  grant;
    logic              multi;

    logic [ADDR_W-1:0] addr_v [N_SRC];
    logic [N_SRC-1:0]  sel_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic              stall_c;

    assign addr_v[SRC_EXMEM_BOT] = addr0;
    assign addr_v[SRC_MEMWB_TOP] = addr1;
    assign addr_v[SRC_MEMWB_BOT] = addr2;
    assign addr_v[SRC_TM1_TOP]   = addr3;
    assign addr_v[SRC_TM1_BOT]   = addr4;

    // In IDLE the served mask is by definition empty.
    assign served_eff = (state_q == SCHED_DRAIN) ? served_q : '0;
    assign pending    = req & ~served_eff;

    sfr_prio_pick u_pick (
        .pending (pending),
        .grant   (grant),
        .multi   (multi)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SCHED_IDLE;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
        end
    end

    always_comb begin
        state_d  = SCHED_IDLE;
        served_d = '0;
        sel_c    = '0;
        wr_en_c  = 1'b0;
        stall_c  = 1'b0;
        if (!flush && pending != '0) begin
            sel_c   = grant;
            wr_en_c = 1'b1;
            if (multi) begin
                stall_c  = 1'b1;
                served_d = served_eff | grant;
                state_d  = SCHED_DRAIN;
            end
        end
    end

    always_comb begin
        wr_addr_c = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel_c[i]) begin
                wr_addr_c = wr_addr_c | addr_v[i];
            end
        end
    end

    // Outputs are forced low while reset is held so no partial write escapes.
    assign sel_signals = reset_n ? sel_c     : '0;
    assign sfr_wr_en   = reset_n ? wr_en_c   : 1'b0;
    assign sfr_wr_addr = reset_n ? wr_addr_c : '0;
    assign stall       = reset_n ? stall_c   : 1'b0;

endmodule

// File: tb/tb_sfr_write_sched.sv
// Directed self-checking bench for sfr_write_sched.
module tb_sfr_write_sched;

    logic       clock;
    logic       reset_n;
    logic       flush;
    logic [4:0] req;
    logic [5:0] addr0, addr1, addr2, addr3, addr4;
    logic [4:0] sel_signals;
    logic       sfr_wr_en;
    logic [5:0] sfr_wr_addr;
    logic       stall;

    int n_checks;
    int n_pass;

    sfr_write_sched #(.ADDR_W(6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .req         (req),
        .addr0       (addr0),
        .addr1       (addr1),
        .addr2       (addr2),
        .addr3       (addr3),
        .addr4       (addr4),
        .sel_signals (sel_signals),
        .sfr_wr_en   (sfr_wr_en),
        .sfr_wr_addr (sfr_wr_addr),
        .stall       (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] e_sel, input logic e_en,
                             input logic [5:0] e_addr, input logic e_stall);
        check({tag, ".sel"},   {27'd0, sel_signals}, {27'd0, e_sel});
        check({tag, ".en"},    {31'd0, sfr_wr_en},   {31'd0, e_en});
        check({tag, ".addr"},  {26'd0, sfr_wr_addr}, {26'd0, e_addr});
        check({tag, ".stall"}, {31'd0, stall},       {31'd0, e_stall});
    endtask

    // Advance past the next rising edge; inputs change and outputs settle before the next edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        flush    = 1'b0;
        req      = 5'b11111;
        addr0 = 6'h20; addr1 = 6'h21; addr2 = 6'h22; addr3 = 6'h23; addr4 = 6'h24;
        #12;
        check_out("reset_hold", 5'b00000, 1'b0, 6'h00, 1'b0);
        req = 5'b00000;
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            #1;
            check_out("idle", 5'b00000, 1'b0, 6'h00, 1'b0);
            tick();
        end

        req = 5'b00100; addr2 = 6'h12;
        #1; check_out("single", 5'b00100, 1'b1, 6'h12, 1'b0);
        tick();
        req = 5'b00000;
        #1; check_out("single_done", 5'b00000, 1'b0, 6'h00, 1'b0);
        tick();

        req = 5'b01010; addr1 = 6'h05; addr3 = 6'h07;
        #1; check_out("pair_c0", 5'b01000, 1'b1, 6'h07, 1'b1);
        tick();
        #1; check_out("pair_c1", 5'b00010, 1'b1, 6'h05, 1'b0);
        tick();
        req = 5'b00000;
        #1; check_out("pair_c2", 5'b00000, 1'b0, 6'h00, 1'b0);
        tick();

        addr0 = 6'h20; addr1 = 6'h21; addr2 = 6'h22; addr3 = 6'h23; addr4 = 6'h24;
        req = 5'b11111;
        #1; check_out("all_c0", 5'b01000, 1'b1, 6'h23, 1'b1);
        tick();
        #1; check_out("all_c1", 5'b10000, 1'b1, 6'h24, 1'b1);
        tick();
        #1; check_out("all_c2", 5'b00010, 1'b1, 6'h21, 1'b1);
        tick();
        #1; check_out("all_c3", 5'b00100, 1'b1, 6'h22, 1'b1);
        tick();
        #1; check_out("all_c4", 5'b00001, 1'b1, 6'h20, 1'b0);
        tick();
        #1; check_out("all_restart", 5'b01000, 1'b1, 6'h23, 1'b1);
        req = 5'b00000;
        #1; check_out("all_drop", 5'b00000, 1'b0, 6'h00, 1'b0);
        tick();

        req = 5'b11111;
        #1; check_out("flush_c0", 5'b01000, 1'b1, 6'h23, 1'b1);
        tick();
        #1; check_out("flush_c1", 5'b10000, 1'b1, 6'h24, 1'b1);
        tick();
        flush = 1'b1;
        #1; check_out("flush_c2", 5'b00000, 1'b0, 6'h00, 1'b0);
        tick();
        flush = 1'b0;
        #1; check_out("flush_c3", 5'b01000, 1'b1, 6'h23, 1'b1);
        req = 5'b00000;
        tick();

        req = 5'b00111; addr0 = 6'h30; addr1 = 6'h31; addr2 = 6'h32;
        #1; check_out("drop_c0", 5'b00010, 1'b1, 6'h31, 1'b1);
        tick();
        req = 5'b00101;
        #1; check_out("drop_c1", 5'b00100, 1'b1, 6'h32, 1'b1);
        tick();
        #1; check_out("drop_c2", 5'b00001, 1'b1, 6'h30, 1'b0);
        tick();
        req = 5'b00000;
        tick();

        addr3 = 6'h0a; addr4 = 6'h0b;
        req = 5'b11000;
        #1; check_out("rst_c0", 5'b01000, 1'b1, 6'h0a, 1'b1);
        tick();
        #1; check_out("rst_c1", 5'b10000, 1'b1, 6'h0b, 1'b0);
        reset_n = 1'b0;
        #1; check_out("rst_held", 5'b00000, 1'b0, 6'h00, 1'b0);
        tick();
        reset_n = 1'b1;
        #1; check_out("rst_restart0", 5'b01000, 1'b1, 6'h0a, 1'b1);
        tick();
        #1; check_out("rst_restart1", 5'b10000, 1'b1, 6'h0b, 1'b0);
        tick();
        req = 5'b00000;
        #1; check_out("final_idle", 5'b00000, 1'b0, 6'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
